seg_torque_shaper: RTL and testbench
====================================

SEG_TORQUE_SHAPER -- requirements
Module: seg_torque_shaper

Interface
REQ-001 SHALL have parameter W, default 12, speed/control width (signed).
REQ-002 SHALL have parameter SS_W, default 8, soft-start counter width.
REQ-003 SHALL have parameter MIN_DUTY, default 960 (0x3C0), deadzone offset.
REQ-004 SHALL have parameter LOW_BAND, default 60 (0x3C), low-torque band threshold.
REQ-005 SHALL have parameter GAIN_MULT, default 16, low-band gain.
REQ-006 SHALL have parameter STEER_LO/STEER_HI, defaults 0x200/0xE00, steer clip limits.
REQ-007 SHALL have parameter FAST_HI/FAST_LO, defaults 1792/1536, too_fast set/clear thresholds.
REQ-008 SHALL have parameter SLEW_STEP, default 0, max output change per sample; 0 disables slew limiting.
REQ-009 SHALL have ports: clk in 1, clock; rst_n in 1, reset. One clock; reset is synchronous and active-low.
REQ-010 SHALL have ports: vld_in in 1, sample strobe; PID_cntrl in W signed; steer_pot in W unsigned; en_steer in 1; pwr_up in 1.
REQ-011 SHALL have ports: vld_out out 1; lft_spd out W signed; rght_spd out W signed; too_fast out 1; ss_done out 1.

Function
REQ-012 Soft-start counter ss_cnt (SS_W bits) SHALL clear on any cycle with pwr_up=0, else increment on vld_in, saturating at all-ones; ss_done = (ss_cnt all-ones).
REQ-013 Stage 1 (on vld_in) SHALL compute PID_ss = (ss_cnt * PID_cntrl) >>> SS_W, using ss_cnt value before that cycle's increment, ss_cnt zero-extended as unsigned.
REQ-014 Stage 1 SHALL clip steer_pot to [STEER_LO, STEER_HI], subtract 2^(W-1)-1, and scale by 3/16 as (x>>>3)+(x>>>4).
REQ-015 Stage 1 SHALL register W+1-bit lft = PID_ss+steer, rght = PID_ss-steer when en_steer=1; both = PID_ss when en_steer=0; pwr_up sampled and carried alongside.
REQ-016 Stage 2 per wheel: |t|>LOW_BAND -> t+MIN_DUTY (t>=0) or t-MIN_DUTY (t<0); else t*GAIN_MULT; carried pwr_up=0 -> 0.
REQ-017 Stage 2 SHALL saturate to W bits: >2^(W-1)-1 -> 0x7FF, <-2^(W-1) -> 0x800 (W=12); no wrap-around ever.
REQ-018 With SLEW_STEP>0, each registered output SHALL move toward its saturated target by at most SLEW_STEP per vld sample; carried pwr_up=0 bypasses slew and forces 0.
REQ-019 vld_out SHALL assert exactly 2 cycles after vld_in; pipeline accepts one sample per cycle; outputs hold between valid samples.
REQ-020 too_fast SHALL set when either output > FAST_HI, clear when both < FAST_LO, else hold; updated only with vld_out.
REQ-021 Back-to-back vld_in with pwr_up toggling SHALL process each sample with its own sampled pwr_up.

Reset
REQ-022 On rst_n=0 at clk edge: ss_cnt, both pipeline stages, lft_spd, rght_spd, vld_out, too_fast, ss_done SHALL be 0.
REQ-023 Reset mid-stream SHALL discard in-flight samples; no vld_out until 2 cycles after first post-reset vld_in.

Structure
REQ-024 Default constants and a shaped-torque typedef SHALL live in package seg_math_pkg.
REQ-025 Per-wheel deadzone/saturate/slew logic SHALL be one sub-module seg_wheel_shaper, instantiated twice.

Verification (defaults, SLEW_STEP=0 unless stated)
REQ-026 Reset: rst_n low 2 cycles during streaming -> next cycle all outputs 0, vld_out 0; first vld_out 2 cycles after next vld_in.
REQ-027 Soft start: pwr_up=1, en_steer=0, PID_cntrl=0x100, vld_in every cycle -> first lft_spd=0, ss_done after 255 samples, final lft_spd=rght_spd=1215.
REQ-028 Low band: ss saturated, PID_cntrl=0x020 -> PID_ss=31 -> lft_spd=rght_spd=496.
REQ-029 Steer clip: PID_cntrl=0, en_steer=1, steer_pot=0xFFF -> steer=288 -> lft_spd=1248, rght_spd=-1248, too_fast=0.
REQ-030 Saturation/hysteresis: ss saturated, PID_cntrl=0x7FF -> both 2047, too_fast=1; then PID_cntrl=0 -> both 0, too_fast=0.
REQ-031 Slew: SLEW_STEP=64, target 1215 from 0 -> lft_spd 64,128,... per sample, reaches 1215 on 19th; pwr_up=0 -> 0 in 2 cycles.

Source files
------------

// File: rtl/seg_math_pkg.sv
// seg_math_pkg
// Shared constants and types for the segway torque shaper.
//   SEG_*     : default parameter values used by seg_torque_shaper and
//               seg_wheel_shaper.
//   shaped_t  : wide signed intermediate for deadzone/gain/slew math. It is
//               wide enough that no intermediate can wrap before saturation.
//   shaped_abs: magnitude helper for shaped_t.
package seg_math_pkg;

  localparam int SEG_W         = 12;
  localparam int SEG_SS_W      = 8;
  localparam int SEG_MIN_DUTY  = 960;
  localparam int SEG_LOW_BAND  = 60;
  localparam int SEG_GAIN_MULT = 16;
  localparam int SEG_STEER_LO  = 512;
  localparam int SEG_STEER_HI  = 3584;
  localparam int SEG_FAST_HI   = 1792;
  localparam int SEG_FAST_LO   = 1536;
  localparam int SEG_SLEW_STEP = 0;

  typedef logic signed [31:0] shaped_t;

  function automatic shaped_t shaped_abs(input shaped_t v);
    shaped_t r;
    if (v < 32'sd0) begin
      r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_wheel_shaper.sv
// seg_wheel_shaper
// One wheel of the second pipeline stage: deadzone offset or low-band gain,
// saturation to W bits, optional slew limiting, registered output.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   vld        : stage-1 sample valid; output register loads only when high
//   pwr_up     : pwr_up sampled with this sample; 0 forces the output to 0
//   torque     : W+1-bit signed stage-1 torque
//   spd_next   : value the output register loads on this vld (for too_fast)
//   spd        : registered, saturated wheel speed
module seg_wheel_shaper
  import seg_math_pkg::*;
#(
  parameter int W         = SEG_W,
  parameter int MIN_DUTY  = SEG_MIN_DUTY,
  parameter int LOW_BAND  = SEG_LOW_BAND,
  parameter int GAIN_MULT = SEG_GAIN_MULT,
  parameter int SLEW_STEP = SEG_SLEW_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vld,
  input  logic                pwr_up,
  input  logic signed [W:0]   torque,
  output logic signed [W-1:0] spd_next,
  output logic signed [W-1:0] spd
);

  localparam int      SAT_MAX_I = (1 << (W - 1)) - 1;
  localparam shaped_t SAT_MAX   = shaped_t'(SAT_MAX_I);
  localparam shaped_t SAT_MIN   = -SAT_MAX - 32'sd1;

  logic signed [W-1:0] spd_r;
  shaped_t             torque_w_s;
  shaped_t             shaped_s;
  shaped_t             sat_w_s;
  shaped_t             cur_w_s;
  shaped_t             diff_s;
  shaped_t             step_w_s;
  shaped_t             slewed_w_s;

  // Deadzone/gain shaping, saturation and slew toward the saturated target.
  always_comb begin
    torque_w_s = {{(31 - W){torque[W]}}, torque};

    // Outside the low band jump over the motor deadzone; inside it, amplify.
    if (shaped_abs(torque_w_s) > shaped_t'(LOW_BAND)) begin
      if (torque_w_s >= 32'sd0) begin
        shaped_s = torque_w_s + shaped_t'(MIN_DUTY);
      end else begin
        shaped_s = torque_w_s - shaped_t'(MIN_DUTY);
      end
    end else begin
      shaped_s = torque_w_s * shaped_t'(GAIN_MULT);
    end

    if (shaped_s > SAT_MAX) begin
      sat_w_s = SAT_MAX;
    end else if (shaped_s < SAT_MIN) begin
      sat_w_s = SAT_MIN;
    end else begin
      sat_w_s = shaped_s;
    end

    cur_w_s  = {{(32 - W){spd_r[W-1]}}, spd_r};
    diff_s   = sat_w_s - cur_w_s;
    step_w_s = shaped_t'(SLEW_STEP);
    if (SLEW_STEP == 0) begin
      slewed_w_s = sat_w_s;
    end else if (diff_s > step_w_s) begin
      slewed_w_s = cur_w_s + step_w_s;
    end else if (diff_s < -step_w_s) begin
      slewed_w_s = cur_w_s - step_w_s;
    end else begin
      slewed_w_s = sat_w_s;
    end

    // Power-down bypasses the slew limiter so the wheel stops at once.
    if (!pwr_up) begin
      spd_next = {W{1'b0}};
    end else begin
      spd_next = W'(slewed_w_s);
    end
  end

  // Output register: loads once per valid sample, holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spd_r <= {W{1'b0}};
    end else if (vld) begin
      spd_r <= spd_next;
    end
  end

  assign spd = spd_r;

endmodule

// File: rtl/seg_torque_shaper.sv
// seg_torque_shaper
// Two-stage torque shaping pipeline for a two-wheel self-balancing platform.
// Stage 1 applies soft-start scaling to the PID command and adds/subtracts a
// scaled steering term; stage 2 (two seg_wheel_shaper instances) applies the
// deadzone, saturation and optional slew limit per wheel.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   vld_in              : sample strobe for PID_cntrl/steer_pot/en_steer/pwr_up
//   PID_cntrl           : W-bit signed balance command
//   steer_pot           : W-bit unsigned steering potentiometer
//   en_steer            : 1 = apply steering differential
//   pwr_up              : 0 = clear soft start and force wheel outputs to 0
//   vld_out             : pulses 2 cycles after each vld_in
//   lft_spd, rght_spd   : W-bit signed wheel speeds, held between samples
//   too_fast            : hysteretic over-speed flag, updated with vld_out
//   ss_done             : soft-start counter saturated
module seg_torque_shaper
  import seg_math_pkg::*;
#(
  parameter int W         = SEG_W,
  parameter int SS_W      = SEG_SS_W,
  parameter int MIN_DUTY  = SEG_MIN_DUTY,
  parameter int LOW_BAND  = SEG_LOW_BAND,
  parameter int GAIN_MULT = SEG_GAIN_MULT,
  parameter int STEER_LO  = SEG_STEER_LO,
  parameter int STEER_HI  = SEG_STEER_HI,
  parameter int FAST_HI   = SEG_FAST_HI,
  parameter int FAST_LO   = SEG_FAST_LO,
  parameter int SLEW_STEP = SEG_SLEW_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vld_in,
  input  logic signed [W-1:0] PID_cntrl,
  input  logic        [W-1:0] steer_pot,
  input  logic                en_steer,
  input  logic                pwr_up,
  output logic                vld_out,
  output logic signed [W-1:0] lft_spd,
  output logic signed [W-1:0] rght_spd,
  output logic                too_fast,
  output logic                ss_done
);

  localparam logic        [SS_W-1:0] SS_MAX     = {SS_W{1'b1}};
  localparam logic        [SS_W-1:0] SS_ONE     = {{(SS_W - 1){1'b0}}, 1'b1};
  localparam logic        [W-1:0]    STEER_LO_V = W'(STEER_LO);
  localparam logic        [W-1:0]    STEER_HI_V = W'(STEER_HI);
  localparam logic signed [W:0]      STEER_MID  = (W + 1)'((1 << (W - 1)) - 1);
  localparam logic signed [W-1:0]    FAST_HI_V  = W'(FAST_HI);
  localparam logic signed [W-1:0]    FAST_LO_V  = W'(FAST_LO);

  logic        [SS_W-1:0]   ss_cnt_r;
  logic        [SS_W-1:0]   ss_cnt_nxt_s;
  logic                     ss_done_r;

  logic signed [SS_W+W:0]   mult_a_s;
  logic signed [SS_W+W:0]   mult_b_s;
  logic signed [SS_W+W:0]   prod_s;
  logic signed [W-1:0]      pid_ss_s;
  logic        [W-1:0]      steer_clip_s;
  logic signed [W:0]        steer_off_s;
  logic signed [W:0]        steer_s;
  logic signed [W:0]        pid_ext_s;
  logic signed [W:0]        lft_nxt_s;
  logic signed [W:0]        rght_nxt_s;

  logic                     v1_r;
  logic                     pwr1_r;
  logic signed [W:0]        lft1_r;
  logic signed [W:0]        rght1_r;

  logic signed [W-1:0]      lft_next_s;
  logic signed [W-1:0]      rght_next_s;
  logic                     vld_out_r;
  logic                     too_fast_r;
  logic                     too_fast_nxt_s;

  // Soft-start counter next value: pwr_up low clears, each sample counts up.
  always_comb begin
    if (!pwr_up) begin
      ss_cnt_nxt_s = {SS_W{1'b0}};
    end else if (vld_in && (ss_cnt_r != SS_MAX)) begin
      ss_cnt_nxt_s = ss_cnt_r + SS_ONE;
    end else begin
      ss_cnt_nxt_s = ss_cnt_r;
    end
  end

  // Soft-start counter and its done flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_cnt_r  <= {SS_W{1'b0}};
      ss_done_r <= 1'b0;
    end else begin
      ss_cnt_r  <= ss_cnt_nxt_s;
      ss_done_r <= &ss_cnt_nxt_s;
    end
  end

  // Stage 1 math: soft-start scaling and the steering differential.
  always_comb begin
    // ss_cnt is an unsigned fraction of full scale, so zero-extend it.
    mult_a_s = {{W{1'b0}}, ss_cnt_r};
    mult_b_s = {{(SS_W + 1){PID_cntrl[W-1]}}, PID_cntrl};
    prod_s   = mult_a_s * mult_b_s;
    pid_ss_s = W'(prod_s >>> SS_W);

    if (steer_pot < STEER_LO_V) begin
      steer_clip_s = STEER_LO_V;
    end else if (steer_pot > STEER_HI_V) begin
      steer_clip_s = STEER_HI_V;
    end else begin
      steer_clip_s = steer_pot;
    end

    // Center the pot around zero, then scale by 3/16 without a multiplier.
    steer_off_s = $signed({1'b0, steer_clip_s}) - STEER_MID;
    steer_s     = (steer_off_s >>> 3'd3) + (steer_off_s >>> 3'd4);
    pid_ext_s   = {pid_ss_s[W-1], pid_ss_s};

    if (en_steer) begin
      lft_nxt_s  = pid_ext_s + steer_s;
      rght_nxt_s = pid_ext_s - steer_s;
    end else begin
      lft_nxt_s  = pid_ext_s;
      rght_nxt_s = pid_ext_s;
    end
  end

  // Stage 1 registers: per-wheel torque plus the pwr_up seen with the sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      pwr1_r  <= 1'b0;
      lft1_r  <= {(W + 1){1'b0}};
      rght1_r <= {(W + 1){1'b0}};
    end else begin
      v1_r <= vld_in;
      if (vld_in) begin
        pwr1_r  <= pwr_up;
        lft1_r  <= lft_nxt_s;
        rght1_r <= rght_nxt_s;
      end
    end
  end

  seg_wheel_shaper #(
    .W         (W),
    .MIN_DUTY  (MIN_DUTY),
    .LOW_BAND  (LOW_BAND),
    .GAIN_MULT (GAIN_MULT),
    .SLEW_STEP (SLEW_STEP)
  ) u_lft (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld      (v1_r),
    .pwr_up   (pwr1_r),
    .torque   (lft1_r),
    .spd_next (lft_next_s),
    .spd      (lft_spd)
  );

  seg_wheel_shaper #(
    .W         (W),
    .MIN_DUTY  (MIN_DUTY),
    .LOW_BAND  (LOW_BAND),
    .GAIN_MULT (GAIN_MULT),
    .SLEW_STEP (SLEW_STEP)
  ) u_rght (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld      (v1_r),
    .pwr_up   (pwr1_r),
    .torque   (rght1_r),
    .spd_next (rght_next_s),
    .spd      (rght_spd)
  );

  // Over-speed hysteresis, judged on the values the wheels are about to load.
  always_comb begin
    if (!v1_r) begin
      too_fast_nxt_s = too_fast_r;
    end else if ((lft_next_s > FAST_HI_V) || (rght_next_s > FAST_HI_V)) begin
      too_fast_nxt_s = 1'b1;
    end else if ((lft_next_s < FAST_LO_V) && (rght_next_s < FAST_LO_V)) begin
      too_fast_nxt_s = 1'b0;
    end else begin
      too_fast_nxt_s = too_fast_r;
    end
  end

  // Output valid strobe and over-speed flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_out_r  <= 1'b0;
      too_fast_r <= 1'b0;
    end else begin
      vld_out_r  <= v1_r;
      too_fast_r <= too_fast_nxt_s;
    end
  end

  assign vld_out  = vld_out_r;
  assign too_fast = too_fast_r;
  assign ss_done  = ss_done_r;

endmodule

// File: tb/tb_seg_torque_shaper.sv
// Self-checking bench for seg_torque_shaper: a default instance and a
// SLEW_STEP=64 instance share stimulus; a reference model pushes expected
// outputs to a scoreboard queue when a sample is driven, and each test task
// pops and compares when vld_out appears.
module tb_seg_torque_shaper;

  typedef struct {
    int lft;
    int rght;
    bit tf;
    int lft_s;
    int rght_s;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vld_in;
  logic signed [11:0] PID_cntrl;
  logic        [11:0] steer_pot;
  logic               en_steer;
  logic               pwr_up;
  logic               vld_out;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               too_fast;
  logic               ss_done;
  logic               vld_out_sl;
  logic signed [11:0] lft_sl;
  logic signed [11:0] rght_sl;
  logic               too_fast_sl;
  logic               ss_done_sl;

  exp_t sb_q[$];
  int   ss_m;
  bit   tf_m;
  int   lft_sm;
  int   rght_sm;
  int   n_vec;
  int   n_fail;

  seg_torque_shaper dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_in    (vld_in),
    .PID_cntrl (PID_cntrl),
    .steer_pot (steer_pot),
    .en_steer  (en_steer),
    .pwr_up    (pwr_up),
    .vld_out   (vld_out),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .too_fast  (too_fast),
    .ss_done   (ss_done)
  );

  seg_torque_shaper #(.SLEW_STEP(64)) dut_slew (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_in    (vld_in),
    .PID_cntrl (PID_cntrl),
    .steer_pot (steer_pot),
    .en_steer  (en_steer),
    .pwr_up    (pwr_up),
    .vld_out   (vld_out_sl),
    .lft_spd   (lft_sl),
    .rght_spd  (rght_sl),
    .too_fast  (too_fast_sl),
    .ss_done   (ss_done_sl)
  );

  always #5 clk = ~clk;

  function automatic int shape(input int t, input bit pw);
    int a;
    int s;
    if (!pw) return 0;
    a = (t < 0) ? -t : t;
    if (a > 60) s = (t >= 0) ? t + 960 : t - 960;
    else        s = t * 16;
    if (s > 2047)  s = 2047;
    if (s < -2048) s = -2048;
    return s;
  endfunction

  function automatic int slew(input int cur, input int tgt, input bit pw);
    int d;
    if (!pw) return 0;
    d = tgt - cur;
    if (d > 64)  return cur + 64;
    if (d < -64) return cur - 64;
    return tgt;
  endfunction

  // Drive one cycle of inputs, update the model, advance to posedge+1.
  task automatic step(input bit v, input int pid, input int pot, input bit es, input bit pw);
    exp_t e;
    int   pss;
    int   clip;
    int   x;
    int   st;
    int   lt;
    int   rt;
    vld_in    = v;
    PID_cntrl = 12'(pid);
    steer_pot = 12'(pot);
    en_steer  = es;
    pwr_up    = pw;
    if (rst_n === 1'b0) begin
      sb_q.delete();
      ss_m = 0; tf_m = 1'b0; lft_sm = 0; rght_sm = 0;
    end else begin
      if (v) begin
        pss  = (ss_m * pid) >>> 8;
        clip = (pot < 512) ? 512 : ((pot > 3584) ? 3584 : pot);
        x    = clip - 2047;
        st   = (x >>> 3) + (x >>> 4);
        lt   = es ? pss + st : pss;
        rt   = es ? pss - st : pss;
        e.lft  = shape(lt, pw);
        e.rght = shape(rt, pw);
        if (e.lft > 1792 || e.rght > 1792)      tf_m = 1'b1;
        else if (e.lft < 1536 && e.rght < 1536) tf_m = 1'b0;
        e.tf     = tf_m;
        lft_sm   = slew(lft_sm, e.lft, pw);
        rght_sm  = slew(rght_sm, e.rght, pw);
        e.lft_s  = lft_sm;
        e.rght_s = rght_sm;
        sb_q.push_back(e);
      end
      if (!pw) ss_m = 0;
      else if (v && ss_m < 255) ss_m = ss_m + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    step(1'b0, 0, 2047, 1'b0, 1'b0);
    step(1'b0, 0, 2047, 1'b0, 1'b0);
    n_vec++;
    if (vld_out !== 1'b0 || lft_spd !== 12'sd0 || rght_spd !== 12'sd0 || too_fast !== 1'b0 || ss_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: vld=%b l=%0d r=%0d tf=%b ssd=%b, want all 0", vld_out, lft_spd, rght_spd, too_fast, ss_done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 256, 3000, 1'b1, 1'b1);
      if (vld_out === 1'b1) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL reset_stream: unexpected vld_out");
        end else begin
          e = sb_q.pop_front();
          if (lft_spd !== e.lft || rght_spd !== e.rght || too_fast !== e.tf) begin
            n_fail++;
            $display("FAIL reset_stream: l=%0d r=%0d tf=%b, want %0d %0d %b", lft_spd, rght_spd, too_fast, e.lft, e.rght, e.tf);
          end
        end
      end
    end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 256, 3000, 1'b1, 1'b1);
      n_vec++;
      if (vld_out !== 1'b0 || lft_spd !== 12'sd0 || rght_spd !== 12'sd0 || too_fast !== 1'b0 || ss_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: vld=%b l=%0d r=%0d tf=%b, want all 0", i, vld_out, lft_spd, rght_spd, too_fast);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 256, 3000, 1'b1, 1'b1);
      n_vec++;
      if (vld_out !== 1'b0) begin
        n_fail++; $display("FAIL reset_flush[%0d]: vld_out=%b, want 0", i, vld_out);
      end
    end
    step(1'b1, 256, 3000, 1'b1, 1'b1);
    n_vec++;
    if (vld_out !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: vld_out=%b one cycle after vld_in, want 0", vld_out);
    end
    step(1'b0, 256, 3000, 1'b1, 1'b1);
    n_vec++;
    if (vld_out !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL latency_two: vld_out=%b two cycles after vld_in, want 1", vld_out);
    end else begin
      e = sb_q.pop_front();
      if (lft_spd !== e.lft || rght_spd !== e.rght) begin
        n_fail++; $display("FAIL latency_two: l=%0d r=%0d, want %0d %0d", lft_spd, rght_spd, e.lft, e.rght);
      end
    end
  endtask

  task automatic test_soft_start();
    exp_t e;
    int   nout;
    nout = 0;
    step(1'b0, 256, 2047, 1'b0, 1'b0);
    for (int i = 0; i < 263; i++) begin
      step(i < 260, 256, 2047, 1'b0, 1'b1);
      n_vec++;
      if (ss_done !== (ss_m == 255)) begin
        n_fail++; $display("FAIL ss_done[%0d]: got %b, want %b", i, ss_done, (ss_m == 255));
      end
      if (vld_out === 1'b1) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL soft_start: unexpected vld_out");
        end else begin
          e = sb_q.pop_front();
          if (lft_spd !== e.lft || rght_spd !== e.rght || too_fast !== e.tf || (nout == 0 && lft_spd !== 12'sd0)) begin
            n_fail++;
            $display("FAIL soft_start[%0d]: l=%0d r=%0d tf=%b, want %0d %0d %b", nout, lft_spd, rght_spd, too_fast, e.lft, e.rght, e.tf);
          end
        end
        nout++;
      end
      if (i == 253 || i == 254) begin
        n_vec++;
        if (ss_done !== (i == 254)) begin
          n_fail++; $display("FAIL ss_done_edge: after %0d samples got %b", i + 1, ss_done);
        end
      end
    end
    n_vec++;
    if (lft_spd !== 12'sd1215 || rght_spd !== 12'sd1215 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL soft_start_final: l=%0d r=%0d left=%0d, want 1215 1215 0", lft_spd, rght_spd, sb_q.size());
    end
  endtask

  task automatic test_low_band();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      step(i < 4, (i % 2 == 0) ? -32 : 32, 2047, 1'b0, 1'b1);
      if (vld_out === 1'b1) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL low_band: unexpected vld_out");
        end else begin
          e = sb_q.pop_front();
          if (lft_spd !== e.lft || rght_spd !== e.rght || too_fast !== e.tf) begin
            n_fail++; $display("FAIL low_band: l=%0d r=%0d tf=%b, want %0d %0d %b", lft_spd, rght_spd, too_fast, e.lft, e.rght, e.tf);
          end
        end
      end
    end
    n_vec++;
    if (lft_spd !== 12'sd496 || rght_spd !== 12'sd496 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL low_band_final: l=%0d r=%0d, want 496 496", lft_spd, rght_spd);
    end
  endtask

  task automatic test_steer();
    exp_t e;
    int   pots[5] = '{4095, 0, 2048, 2047, 4095};
    for (int i = 0; i < 8; i++) begin
      step(i < 5, 0, pots[(i < 5) ? i : 4], 1'b1, 1'b1);
      if (vld_out === 1'b1) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL steer: unexpected vld_out");
        end else begin
          e = sb_q.pop_front();
          if (lft_spd !== e.lft || rght_spd !== e.rght || too_fast !== e.tf) begin
            n_fail++; $display("FAIL steer: l=%0d r=%0d tf=%b, want %0d %0d %b", lft_spd, rght_spd, too_fast, e.lft, e.rght, e.tf);
          end
        end
      end
    end
    n_vec++;
    if (lft_spd !== 12'sd1248 || rght_spd !== -12'sd1248 || too_fast !== 1'b0 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL steer_clip: l=%0d r=%0d tf=%b, want 1248 -1248 0", lft_spd, rght_spd, too_fast);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int   pids[5] = '{2047, 700, 0, -2048, 700};
    for (int i = 0; i < 8; i++) begin
      step(i < 5, pids[(i < 5) ? i : 4], 2047, 1'b0, 1'b1);
      if (vld_out === 1'b1) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL saturation: unexpected vld_out");
        end else begin
          e = sb_q.pop_front();
          if (lft_spd !== e.lft || rght_spd !== e.rght || too_fast !== e.tf) begin
            n_fail++; $display("FAIL saturation: l=%0d r=%0d tf=%b, want %0d %0d %b", lft_spd, rght_spd, too_fast, e.lft, e.rght, e.tf);
          end
        end
      end
      if (i == 1 || i == 2 || i == 3 || i == 4) begin
        n_vec++;
        if ((i == 1 && (lft_spd !== 12'sd2047 || rght_spd !== 12'sd2047 || too_fast !== 1'b1)) ||
            (i == 2 && (lft_spd !== 12'sd1657 || too_fast !== 1'b1)) ||
            (i == 3 && (lft_spd !== 12'sd0 || rght_spd !== 12'sd0 || too_fast !== 1'b0)) ||
            (i == 4 && (lft_spd !== -12'sd2048 || rght_spd !== -12'sd2048 || too_fast !== 1'b0))) begin
          n_fail++; $display("FAIL sat_hyst[%0d]: l=%0d r=%0d tf=%b", i, lft_spd, rght_spd, too_fast);
        end
      end
    end
    n_vec++;
    if (lft_spd !== 12'sd1657 || too_fast !== 1'b0 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL hyst_hold_low: l=%0d tf=%b, want 1657 0", lft_spd, too_fast);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      step(i < 8, 256, 4095, 1'b1, (i < 8) ? (i % 2 == 0) : 1'b1);
      if (vld_out === 1'b1) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL back_to_back: unexpected vld_out");
        end else begin
          e = sb_q.pop_front();
          if (lft_spd !== e.lft || rght_spd !== e.rght || too_fast !== e.tf) begin
            n_fail++; $display("FAIL back_to_back: l=%0d r=%0d tf=%b, want %0d %0d %b", lft_spd, rght_spd, too_fast, e.lft, e.rght, e.tf);
          end
        end
      end
      if (i == 1 || i == 2 || i == 3) begin
        n_vec++;
        if ((i == 1 && (lft_spd !== 12'sd1503 || rght_spd !== -12'sd528)) ||
            (i == 2 && (lft_spd !== 12'sd0 || rght_spd !== 12'sd0)) ||
            (i == 3 && (lft_spd !== 12'sd1248 || rght_spd !== -12'sd1248))) begin
          n_fail++; $display("FAIL b2b_pwr[%0d]: l=%0d r=%0d", i, lft_spd, rght_spd);
        end
      end
    end
    n_vec++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: %0d samples missing, want 0", sb_q.size());
    end
  endtask

  task automatic test_slew();
    exp_t e;
    int   j;
    int   want;
    for (int i = 0; i < 282; i++) begin
      step(i < 279, (i < 256) ? 0 : 256, 2047, 1'b0, (i == 278) ? 1'b0 : 1'b1);
      if (vld_out_sl === 1'b1) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL slew: unexpected vld_out");
        end else begin
          e = sb_q.pop_front();
          if (lft_sl !== e.lft_s || rght_sl !== e.rght_s || lft_spd !== e.lft) begin
            n_fail++; $display("FAIL slew: sl=%0d sr=%0d l=%0d, want %0d %0d %0d", lft_sl, rght_sl, lft_spd, e.lft_s, e.rght_s, e.lft);
          end
        end
      end
      j = i - 257;
      if (j >= 0 && j <= 22) begin
        want = (j == 22) ? 0 : (((j + 1) * 64 > 1215) ? 1215 : (j + 1) * 64);
        n_vec++;
        if (lft_sl !== 12'(want)) begin
          n_fail++; $display("FAIL slew_ramp[%0d]: got %0d, want %0d", j, lft_sl, want);
        end
      end
    end
    n_vec++;
    if (lft_sl !== 12'sd0 || too_fast_sl !== 1'b0 || ss_done_sl !== 1'b0 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL slew_pwrdn: l=%0d tf=%b ssd=%b, want 0 0 0", lft_sl, too_fast_sl, ss_done_sl);
    end
  endtask

  initial begin
    n_vec = 0; n_fail = 0;
    ss_m = 0; tf_m = 1'b0; lft_sm = 0; rght_sm = 0;
    rst_n = 1'b0; vld_in = 1'b0; PID_cntrl = 12'sd0; steer_pot = 12'd2047;
    en_steer = 1'b0; pwr_up = 1'b0;
    test_reset();
    test_soft_start();
    test_low_band();
    test_steer();
    test_saturation();
    test_back_to_back();
    test_slew();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
